// File: rtl/mult_seq_param.sv
// Sequential chunked multiplier: one A_CHUNK x B_CHUNK partial product per cycle,
// optional two's-complement mode, registered product and done pulse.
module mult_seq_param #(
  parameter int A_WIDTH = 32,
  parameter int B_WIDTH = 32,
  parameter int A_CHUNK = 8,
  parameter int B_CHUNK = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       is_signed,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  output logic                       busy,
  output logic                       done,
  output logic [A_WIDTH+B_WIDTH-1:0] product
);

  localparam int NA = A_WIDTH / A_CHUNK;
  localparam int NB = B_WIDTH / B_CHUNK;
  localparam int P  = A_WIDTH + B_WIDTH;
  localparam int C  = A_CHUNK + B_CHUNK;
  localparam int IW = (NA > 1) ? $clog2(NA) : 1;
  localparam int JW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]         r_state;
  logic [A_WIDTH-1:0] r_a;
  logic [B_WIDTH-1:0] r_b;
  logic               r_neg;
  logic [P-1:0]       r_acc;
  logic [IW-1:0]      r_i;
  logic [JW-1:0]      r_j;
  logic               r_done;
  logic [P-1:0]       r_product;

  logic [A_WIDTH-1:0] w_amag;
  logic [B_WIDTH-1:0] w_bmag;
  logic               w_neg;
  logic [31:0]        w_ia;
  logic [31:0]        w_jb;
  logic [31:0]        w_sh;
  logic [A_CHUNK-1:0] w_ach;
  logic [B_CHUNK-1:0] w_bch;
  logic [C-1:0]       w_pp;
  logic [P-1:0]       w_term;
  logic               w_last_i;
  logic               w_last_j;

  // Magnitude of the most-negative value still fits unsigned in W bits
  assign w_amag = (is_signed && a[A_WIDTH-1]) ? (~a + A_WIDTH'(1)) : a;
  assign w_bmag = (is_signed && b[B_WIDTH-1]) ? (~b + B_WIDTH'(1)) : b;
  assign w_neg  = is_signed & (a[A_WIDTH-1] ^ b[B_WIDTH-1]);

  assign w_ia  = 32'(r_i) * 32'(A_CHUNK);
  assign w_jb  = 32'(r_j) * 32'(B_CHUNK);
  assign w_sh  = w_ia + w_jb;
  assign w_ach = A_CHUNK'(r_a >> w_ia);
  assign w_bch = B_CHUNK'(r_b >> w_jb);

  assign w_pp   = C'(w_ach) * C'(w_bch);
  assign w_term = P'(w_pp) << w_sh;

  assign w_last_i = (r_i == IW'(NA - 1));
  assign w_last_j = (r_j == JW'(NB - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_i       <= '0;
      r_j       <= '0;
      r_done    <= 1'b0;
      r_product <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= w_amag;
            r_b     <= w_bmag;
            r_neg   <= w_neg;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= S_MULT;
          end
        end
        S_MULT: begin
          r_acc <= r_acc + w_term;
          // A chunks are the inner loop, B chunks the outer
          if (w_last_i) begin
            r_i <= '0;
            if (w_last_j) begin
              r_state <= S_FIN;
            end else begin
              r_j <= r_j + JW'(1);
            end
          end else begin
            r_i <= r_i + IW'(1);
          end
        end
        S_FIN: begin
          r_product <= r_neg ? (~r_acc + P'(1)) : r_acc;
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign product = r_product;

endmodule

// File: tb/tb_mult_seq_param.sv
// Directed bench for mult_seq_param: default 32x32 instance and an 8x8
// instance with 4-bit chunks.
module tb_mult_seq_param;

  logic        clk;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  logic        v_start;
  logic        v_is_signed;
  logic [7:0]  v_a;
  logic [7:0]  v_b;
  logic        v_busy;
  logic        v_done;
  logic [15:0] v_product;

  int checks;
  int errors;

  mult_seq_param u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  mult_seq_param #(
    .A_WIDTH (8),
    .B_WIDTH (8),
    .A_CHUNK (4),
    .B_CHUNK (4)
  ) u_small (
    .clk       (clk),
    .reset     (reset),
    .start     (v_start),
    .is_signed (v_is_signed),
    .a         (v_a),
    .b         (v_b),
    .busy      (v_busy),
    .done      (v_done),
    .product   (v_product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [31:0] ia, input logic [31:0] ib,
                    input logic s);
    a = ia;
    b = ib;
    is_signed = s;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic v_wait_done(output int n);
    n = 0;
    while (v_done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick;
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'h0) begin
      errors++;
      $display("FAIL reset_big busy=%b done=%b product=%h want 0 0 0",
               busy, done, product);
    end
    checks++;
    if (v_busy !== 1'b0 || v_done !== 1'b0 || v_product !== 16'h0) begin
      errors++;
      $display("FAIL reset_small busy=%b done=%b product=%h want 0 0 0",
               v_busy, v_done, v_product);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_unsigned_max;
    go(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL umax_busy cyc=%0d busy=%b done=%b want 1 0",
                 c, busy, done);
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL umax_done done=%b busy=%b want 1 0", done, busy);
    end
    checks++;
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      errors++;
      $display("FAIL umax_product got %h want fffffffe00000001", product);
    end
    tick;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL umax_pulse done=%b want 0", done);
    end
  endtask

  task automatic test_signed;
    logic [31:0] ta [5];
    logic [31:0] tb [5];
    logic        ts [5];
    logic [63:0] te [5];
    int n;
    ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h1;
    ts[0] = 1'b1; te[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    ta[1] = 32'h8000_0000; tb[1] = 32'h8000_0000;
    ts[1] = 1'b1; te[1] = 64'h4000_0000_0000_0000;
    ta[2] = 32'h8000_0000; tb[2] = 32'h8000_0000;
    ts[2] = 1'b0; te[2] = 64'h4000_0000_0000_0000;
    ta[3] = 32'h8000_0000; tb[3] = 32'h1;
    ts[3] = 1'b1; te[3] = 64'hFFFF_FFFF_8000_0000;
    ta[4] = 32'hFFFF_FFFD; tb[4] = 32'h5;
    ts[4] = 1'b1; te[4] = 64'hFFFF_FFFF_FFFF_FFF1;
    for (int k = 0; k < 5; k++) begin
      go(ta[k], tb[k], ts[k]);
      wait_done(n);
      checks++;
      if (n != 9) begin
        errors++;
        $display("FAIL signed_lat case=%0d got %0d want 9", k, n);
      end
      checks++;
      if (product !== te[k]) begin
        errors++;
        $display("FAIL signed_product case=%0d got %h want %h",
                 k, product, te[k]);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int m;
    a = 32'h1234_5678;
    b = 32'h2;
    is_signed = 1'b0;
    start = 1'b1;
    tick;
    a = 32'hDEAD_BEEF;
    b = 32'hCAFE_BABE;
    is_signed = 1'b1;
    tick;
    tick;
    tick;
    a = 32'h3;
    b = 32'h5;
    is_signed = 1'b0;
    wait_done(n);
    checks++;
    if (n != 6 || product !== 64'h2468_ACF0) begin
      errors++;
      $display("FAIL b2b_first n=%0d product=%h want 6 2468acf0", n, product);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_in_done busy=%b want 0", busy);
    end
    tick;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept busy=%b want 1", busy);
    end
    wait_done(m);
    start = 1'b0;
    checks++;
    if (m + 1 != 10) begin
      errors++;
      $display("FAIL b2b_spacing got %0d want 10", m + 1);
    end
    checks++;
    if (product !== 64'hF) begin
      errors++;
      $display("FAIL b2b_second product=%h want f", product);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    go(32'h1234, 32'h5678, 1'b0);
    tick;
    tick;
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'h0) begin
      errors++;
      $display("FAIL midreset busy=%b done=%b product=%h want 0 0 0",
               busy, done, product);
    end
    reset = 1'b1;
    tick;
    go(32'h10, 32'h10, 1'b0);
    wait_done(n);
    checks++;
    if (n != 9 || product !== 64'h100) begin
      errors++;
      $display("FAIL midreset_after n=%0d product=%h want 9 100", n, product);
    end
    tick;
  endtask

  task automatic test_zero;
    go(32'h1234_5678, 32'h0, 1'b0);
    for (int c = 0; c < 9; c++) begin
      checks++;
      if (product !== 64'h100 || done !== 1'b0) begin
        errors++;
        $display("FAIL zero_hold cyc=%0d product=%h done=%b want 100 0",
                 c, product, done);
      end
      tick;
    end
    checks++;
    if (done !== 1'b1 || product !== 64'h0) begin
      errors++;
      $display("FAIL zero_result done=%b product=%h want 1 0", done, product);
    end
    tick;
  endtask

  task automatic test_variant;
    logic [7:0]  ta [3];
    logic [7:0]  tb [3];
    logic        ts [3];
    logic [15:0] te [3];
    int n;
    ta[0] = 8'd200; tb[0] = 8'd150; ts[0] = 1'b0; te[0] = 16'h7530;
    ta[1] = 8'h80;  tb[1] = 8'h80;  ts[1] = 1'b1; te[1] = 16'h4000;
    ta[2] = 8'hFF;  tb[2] = 8'h02;  ts[2] = 1'b1; te[2] = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      v_a = ta[k];
      v_b = tb[k];
      v_is_signed = ts[k];
      v_start = 1'b1;
      tick;
      v_start = 1'b0;
      v_wait_done(n);
      checks++;
      if (n != 5) begin
        errors++;
        $display("FAIL small_lat case=%0d got %0d want 5", k, n);
      end
      checks++;
      if (v_product !== te[k]) begin
        errors++;
        $display("FAIL small_product case=%0d got %h want %h",
                 k, v_product, te[k]);
      end
      tick;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    start = 1'b0;
    is_signed = 1'b0;
    a = '0;
    b = '0;
    v_start = 1'b0;
    v_is_signed = 1'b0;
    v_a = '0;
    v_b = '0;
    test_reset;
    test_unsigned_max;
    test_signed;
    test_back_to_back;
    test_reset_mid;
    test_zero;
    test_variant;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
